bscac7_tsv_fifo_bank: RTL and testbench

Per-lane buffering and TSV state register of the BSCAC7 encoder, directly upstream of the FIFO control generator. It accepts 7-bit transformed words and splits each word bit-wise into seven lane FIFOs: lane 0 is the DTSV, lanes 1..6 are data TSVs. Every cycle it presents the lane heads as next-state candidates, together with the registered current TSV state. It then pops the lanes that the control generator marks free and advances the TSV state register.

---
 rtl/bscac7_tsv_fifo_bank.sv | 115 +++++++++++
 tb/tb_bscac7_tsv_fifo_bank.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bscac7_tsv_fifo_bank.sv
// BSCAC7 encoder lane buffering and TSV state register.
// Each incoming 7-bit word is split bit-wise into seven 1-bit lane FIFOs
// (lane 0 = DTSV, lanes 1..6 = data TSVs). Lane heads are offered to the
// FIFO control generator as next-state candidates; lanes marked free are
// popped and their head becomes the new registered TSV drive value.
module bscac7_tsv_fifo_bank #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic [6:1] ctrl_signals,
    output logic [6:0] tsvs_state_current,
    output logic [6:0] data_2b_trans,
    output logic [6:0] lane_empty,
    output logic       bank_idle
);

    localparam int               LANES    = 7;
    localparam logic [ADDR_W:0]  CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]  CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DEPTH-1:0]  mem  [LANES];
    logic [ADDR_W-1:0] wptr [LANES];
    logic [ADDR_W-1:0] rptr [LANES];
    logic [ADDR_W:0]   cnt  [LANES];

    logic [LANES-1:0] not_full;
    logic [LANES-1:0] head;
    logic [LANES-1:0] pop;
    logic [LANES-1:0] tsv_q;
    logic             wr_en;

    // Per-lane status and head bit, derived only from registered state.
    always_comb begin
        lane_empty = '0;
        not_full   = '0;
        head       = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_empty[i] = (cnt[i] == '0);
            not_full[i]   = (cnt[i] < CNT_FULL);
            head[i]       = mem[i][rptr[i]];
        end
    end

    // Accept a word only when every lane has room at the start of the cycle;
    // a same-cycle pop never creates space for the write.
    always_comb begin
        din_ready = !rst && (&not_full);
        wr_en     = din_valid && din_ready;
        bank_idle = &lane_empty;
    end

    // Candidates: an empty lane reports its current TSV value so it reads as
    // unchanged; nothing here depends on ctrl_signals.
    always_comb begin
        data_2b_trans = '0;
        for (int i = 0; i < LANES; i++) begin
            data_2b_trans[i] = lane_empty[i] ? tsv_q[i] : head[i];
        end
    end

    // Pop select: DTSV drains whenever it holds data, data lanes only when
    // freed by the control generator; requests on empty lanes are ignored.
    always_comb begin
        pop    = '0;
        pop[0] = !lane_empty[0];
        for (int i = 1; i < LANES; i++) begin
            pop[i] = ctrl_signals[i] && !lane_empty[i];
        end
    end

    // Pointer, count and TSV state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
            tsv_q <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_en) begin
                    wptr[i] <= wptr[i] + PTR_ONE;
                end
                if (pop[i]) begin
                    rptr[i]  <= rptr[i] + PTR_ONE;
                    tsv_q[i] <= head[i];
                end
                case ({wr_en, pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + CNT_ONE;
                    2'b01:   cnt[i] <= cnt[i] - CNT_ONE;
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    // Lane storage; write enable already excludes reset cycles.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                mem[i][wptr[i]] <= din[i];
            end
        end
    end

    assign tsvs_state_current = tsv_q;

endmodule

// File: tb/tb_bscac7_tsv_fifo_bank.sv
// Testbench for bscac7_tsv_fifo_bank: directed scenarios plus a randomized
// run, all compared against a queue-based lane model.
module tb_bscac7_tsv_fifo_bank;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] din = '0;
    logic       din_valid = 1'b0;
    logic [6:1] ctrl_signals = '0;
    logic       din_ready;
    logic [6:0] tsvs_state_current;
    logic [6:0] data_2b_trans;
    logic [6:0] lane_empty;
    logic       bank_idle;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one queue of bits per lane plus the TSV state.
    bit         mq [7][$];
    logic [6:0] mtsv = '0;

    logic [22:0] dut_vec;
    assign dut_vec = {tsvs_state_current, data_2b_trans, lane_empty, bank_idle, din_ready};

    bscac7_tsv_fifo_bank #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .din                (din),
        .din_valid          (din_valid),
        .din_ready          (din_ready),
        .ctrl_signals       (ctrl_signals),
        .tsvs_state_current (tsvs_state_current),
        .data_2b_trans      (data_2b_trans),
        .lane_empty         (lane_empty),
        .bank_idle          (bank_idle)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    // Expected {tsv, candidates, empty, idle, ready} from the model.
    function automatic logic [22:0] exp_vec();
        logic [6:0] e;
        logic [6:0] dt;
        logic       rdy;
        rdy = !rst;
        e   = '0;
        dt  = '0;
        for (int i = 0; i < 7; i++) begin
            e[i] = (mq[i].size() == 0);
            if (e[i]) dt[i] = mtsv[i];
            else      dt[i] = mq[i][0];
            if (mq[i].size() >= DEPTH) rdy = 1'b0;
        end
        return {mtsv, dt, e, &e, rdy};
    endfunction

    // Drive one cycle of stimulus, advance the model at the edge, settle.
    task automatic cyc(input logic r, input logic v, input logic [6:0] d, input logic [6:1] c);
        logic       rdy;
        logic [6:0] cf;
        @(negedge clk);
        rst = r; din_valid = v; din = d; ctrl_signals = c;
        @(posedge clk);
        cf  = {c, 1'b1};
        rdy = !r;
        for (int i = 0; i < 7; i++) if (mq[i].size() >= DEPTH) rdy = 1'b0;
        if (r) begin
            for (int i = 0; i < 7; i++) mq[i].delete();
            mtsv = '0;
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (mq[i].size() > 0 && cf[i]) mtsv[i] = mq[i].pop_front();
                if (v && rdy) mq[i].push_back(d[i]);
                assert (mq[i].size() <= DEPTH);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b1, 7'h7F, 6'h3F);
        cyc(1'b1, 1'b1, 7'h7F, 6'h3F);
        n_cmp++;
        if (dut_vec !== {7'h00, 7'h00, 7'h7F, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h", dut_vec, {7'h00, 7'h00, 7'h7F, 1'b1, 1'b0});
        end
        cyc(1'b0, 1'b0, 7'h00, 6'h3F);
        n_cmp++;
        if (din_ready !== 1'b1 || bank_idle !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: got ready=%b idle=%b want ready=1 idle=1", din_ready, bank_idle);
        end
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_model: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_single_word();
        cyc(1'b0, 1'b1, 7'b1010101, 6'h3F);
        n_cmp++;
        if (data_2b_trans !== 7'b1010101) begin
            n_err++;
            $display("FAIL single_cand: got %b want %b", data_2b_trans, 7'b1010101);
        end
        cyc(1'b0, 1'b0, 7'h00, 6'h3F);
        n_cmp++;
        if (tsvs_state_current !== 7'b1010101 || bank_idle !== 1'b1) begin
            n_err++;
            $display("FAIL single_state: got tsv=%b idle=%b want tsv=1010101 idle=1", tsvs_state_current, bank_idle);
        end
    endtask

    task automatic test_locked_lane();
        logic [6:0] w;
        for (int k = 0; k < DEPTH; k++) begin
            w = 7'($urandom) | 7'h08;
            cyc(1'b0, 1'b1, w, 6'b111011);
            n_cmp++;
            if (tsvs_state_current[3] !== 1'b0 || din_ready !== (k < DEPTH - 1)) begin
                n_err++;
                $display("FAIL locked_fill[%0d]: got tsv3=%b ready=%b want tsv3=0 ready=%b",
                         k, tsvs_state_current[3], din_ready, (k < DEPTH - 1));
            end
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL locked_model[%0d]: got %h want %h", k, dut_vec, exp_vec());
            end
        end
        cyc(1'b0, 1'b1, 7'h00, 6'b111011);
        n_cmp++;
        if (din_ready !== 1'b0 || dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL locked_full_hold: got %h want %h", dut_vec, exp_vec());
        end
        cyc(1'b0, 1'b0, 7'h00, 6'h3F);
        n_cmp++;
        if (tsvs_state_current[3] !== 1'b1 || din_ready !== 1'b1) begin
            n_err++;
            $display("FAIL locked_release: got tsv3=%b ready=%b want tsv3=1 ready=1",
                     tsvs_state_current[3], din_ready);
        end
        for (int k = 0; k < 2 * DEPTH && bank_idle !== 1'b1; k++) cyc(1'b0, 1'b0, 7'h00, 6'h3F);
        n_cmp++;
        if (bank_idle !== 1'b1 || dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL locked_drain: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_empty_mask();
        cyc(1'b0, 1'b1, 7'b0110011, 6'h3F);
        cyc(1'b0, 1'b0, 7'h00, 6'h3F);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 7'h00, 6'h3F);
            n_cmp++;
            if (data_2b_trans !== 7'b0110011 || tsvs_state_current !== 7'b0110011 || lane_empty !== 7'h7F) begin
                n_err++;
                $display("FAIL empty_mask[%0d]: got cand=%b tsv=%b empty=%h want cand=0110011 tsv=0110011 empty=7f",
                         k, data_2b_trans, tsvs_state_current, lane_empty);
            end
        end
        cyc(1'b0, 1'b1, 7'b1001100, 6'h3F);
        n_cmp++;
        if (data_2b_trans !== 7'b1001100) begin
            n_err++;
            $display("FAIL empty_then_write: got %b want %b", data_2b_trans, 7'b1001100);
        end
        cyc(1'b0, 1'b0, 7'h00, 6'h3F);
        n_cmp++;
        if (tsvs_state_current !== 7'b1001100 || dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL empty_then_pop: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_streaming();
        logic [6:0] w;
        logic [6:0] prev_w;
        prev_w = tsvs_state_current === 7'b1001100 ? 7'b1001100 : mtsv;
        for (int k = 0; k < 20; k++) begin
            w = 7'($urandom);
            cyc(1'b0, 1'b1, w, 6'h3F);
            n_cmp++;
            if (tsvs_state_current !== prev_w || data_2b_trans !== w || din_ready !== 1'b1) begin
                n_err++;
                $display("FAIL stream[%0d]: got tsv=%h cand=%h ready=%b want tsv=%h cand=%h ready=1",
                         k, tsvs_state_current, data_2b_trans, din_ready, prev_w, w);
            end
            prev_w = w;
        end
        cyc(1'b0, 1'b0, 7'h00, 6'h3F);
        n_cmp++;
        if (tsvs_state_current !== prev_w || bank_idle !== 1'b1) begin
            n_err++;
            $display("FAIL stream_tail: got tsv=%h idle=%b want tsv=%h idle=1", tsvs_state_current, bank_idle, prev_w);
        end
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 7'($urandom) | 7'h04, 6'b111101);
        cyc(1'b1, 1'b1, 7'($urandom), 6'h3F);
        n_cmp++;
        if (dut_vec !== {7'h00, 7'h00, 7'h7F, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL midrst_state: got %h want %h", dut_vec, {7'h00, 7'h00, 7'h7F, 1'b1, 1'b0});
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, 7'h00, 6'h3F);
            n_cmp++;
            if (data_2b_trans !== 7'h00 || lane_empty !== 7'h7F || din_ready !== 1'b1) begin
                n_err++;
                $display("FAIL midrst_stale[%0d]: got cand=%h empty=%h ready=%b want cand=00 empty=7f ready=1",
                         k, data_2b_trans, lane_empty, din_ready);
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            cyc(1'b0, 1'b1, 7'($urandom), 6'b111101);
            n_cmp++;
            if (din_ready !== (k < DEPTH - 1)) begin
                n_err++;
                $display("FAIL midrst_count[%0d]: got ready=%b want %b", k, din_ready, (k < DEPTH - 1));
            end
        end
        for (int k = 0; k < 2 * DEPTH; k++) cyc(1'b0, 1'b0, 7'h00, 6'h3F);
    endtask

    task automatic test_random();
        logic       r;
        logic       v;
        logic [6:1] c;
        for (int k = 0; k < 400; k++) begin
            r = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 3) != 0);
            c = 6'($urandom) | 6'($urandom);
            cyc(r, v, 7'($urandom), c);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL random[%0d]: got %h want %h", k, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_locked_lane();
        test_empty_mask();
        test_streaming();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
